renas_line_fill_master: RTL

- AHB-side cache-line transfer engine for the renas mcu.
- Sits directly upstream of the main memory slave on the D-AHB or I-AHB interface.
- Converts one cache-line request from the L1 miss handler into a sequence of single-word AHB transfers: LINE_WORDS reads for a refill, or LINE_WORDS writes for a writeback.
- Paces each beat to the slave's hsel / hreadyout pulse handshake, buffers the line, and returns one response per request.

---
 rtl/renas_line_fill_master.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/renas_line_fill_master.sv
// rtl/renas_line_fill_master.sv - cache-line refill/writeback engine driving single-word AHB beats
// Each beat is held on hsel until a hreadyout pulse; beats are separated by a mandatory idle gap.
module renas_line_fill_master #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_LENGTH = 32,
  parameter int LINE_WORDS  = 4,
  parameter int IDLE_GAP    = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk_l2,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [ADDR_LENGTH-1:0]            req_addr,
  input  logic [LINE_WORDS*DATA_LENGTH-1:0] req_wline,
  output logic                              rsp_valid,
  output logic                              rsp_err,
  output logic [LINE_WORDS*DATA_LENGTH-1:0] rsp_rline,
  output logic                              hsel,
  output logic [ADDR_LENGTH-1:0]            haddr,
  output logic                              hwrite,
  output logic [DATA_LENGTH-1:0]            hwdata,
  input  logic                              hreadyout,
  input  logic [DATA_LENGTH-1:0]            hrdata
);

  localparam int BW   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int OFFB = $clog2(LINE_WORDS * 4);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int GW   = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic [ADDR_LENGTH-1:0] OFF_MASK = ADDR_LENGTH'((1 << OFFB) - 1);

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_GAP, S_RESP} state_t;

  state_t                              state_q;
  logic [BW-1:0]                       beat_q;
  logic [BW-1:0]                       beat_d;
  logic [TW-1:0]                       tmo_q;
  logic [GW-1:0]                       gap_q;
  logic [ADDR_LENGTH-1:0]              base_q;
  logic [ADDR_LENGTH-1:0]              base_d;
  logic [ADDR_LENGTH-1:0]              beat_addr_d;
  logic [DATA_LENGTH-1:0]              beat_data_d;
  logic                                wr_q;
  logic                                err_q;
  logic [LINE_WORDS*DATA_LENGTH-1:0]   line_q;
  logic                                hsel_q;
  logic [ADDR_LENGTH-1:0]              haddr_q;
  logic                                hwrite_q;
  logic [DATA_LENGTH-1:0]              hwdata_q;
  logic                                rsp_valid_q;

  // beat_q already points at the upcoming beat while in GAP
  always_comb begin
    base_d      = req_addr & ~OFF_MASK;
    beat_d      = beat_q + 1'b1;
    beat_addr_d = base_q + {{(ADDR_LENGTH-BW-2){1'b0}}, beat_q, 2'b00};
    beat_data_d = wr_q ? line_q[beat_q*DATA_LENGTH +: DATA_LENGTH] : '0;
  end

  always_ff @(posedge clk_l2 or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
      base_q      <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      line_q      <= '0;
      hsel_q      <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            base_q   <= base_d;
            wr_q     <= req_write;
            line_q   <= req_write ? req_wline : '0;
            beat_q   <= '0;
            tmo_q    <= '0;
            hsel_q   <= 1'b1;
            haddr_q  <= base_d;
            hwrite_q <= req_write;
            hwdata_q <= req_write ? req_wline[DATA_LENGTH-1:0] : '0;
            state_q  <= S_BEAT;
          end
        end
        S_BEAT: begin
          if (hreadyout) begin
            if (!wr_q) begin
              line_q[beat_q*DATA_LENGTH +: DATA_LENGTH] <= hrdata;
            end
            hsel_q   <= 1'b0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            if (beat_q == BW'(LINE_WORDS - 1)) begin
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              beat_q  <= beat_d;
              gap_q   <= '0;
              state_q <= S_GAP;
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            hsel_q      <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q == GW'(IDLE_GAP - 1)) begin
            tmo_q    <= '0;
            hsel_q   <= 1'b1;
            haddr_q  <= beat_addr_d;
            hwrite_q <= wr_q;
            hwdata_q <= beat_data_d;
            state_q  <= S_BEAT;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          err_q       <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q & err_q;
  assign rsp_rline = (rsp_valid_q && !wr_q) ? line_q : '0;
  assign hsel      = hsel_q;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hwdata    = hwdata_q;

endmodule
